// File: rtl/lookup_arbiter.sv
// Two-port arbiter in front of a shared translation lookup FSM (IDLE/ISSUE/RESULT/SEND).
// Optional per-port grant counters are built when RAB_ARB_PERF_CNT_EN is defined.
module lookup_arbiter #(
  parameter int unsigned PRIO_MODE    = 0,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        Clk_CI,
  input  logic        Rst_RI,
  input  logic        port1_req_valid,
  input  logic        port2_req_valid,
  input  logic        port1_accept,
  input  logic        port1_drop,
  input  logic        port2_accept,
  input  logic        port2_drop,
  input  logic        port1_sent,
  input  logic        port2_sent,
  output logic        port1_addr_valid,
  output logic        port2_addr_valid,
  output logic        select,
  output logic        port1_grant,
  output logic        port2_grant,
  output logic        busy,
`ifdef RAB_ARB_PERF_CNT_EN
  output logic [31:0] port1_grant_cnt,
  output logic [31:0] port2_grant_cnt,
`endif
  output logic        protocol_err
);

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, RESULT, SEND} state_e;

  state_e            state_q, state_d;
  logic              select_d, grant1_d, grant2_d, av1_d, av2_d, busy_d, err_d;
  logic              last_p1_q, last_p1_d;
  logic [CntW-1:0]   loss_cnt_q, loss_cnt_d;
  logic              win_p1, hi_is_p1, starved, contention;
  logic              w_accept, w_drop, w_sent, nonwin_evt, any_evt;

  assign hi_is_p1   = (PRIO_MODE == 32'd1);
  assign starved    = (loss_cnt_q == CntW'(STARVE_LIMIT));
  assign contention = port1_req_valid & port2_req_valid;

  assign w_accept   = select ? port1_accept : port2_accept;
  assign w_drop     = select ? port1_drop   : port2_drop;
  assign w_sent     = select ? port1_sent   : port2_sent;
  assign nonwin_evt = select ? (port2_accept | port2_drop) : (port1_accept | port1_drop);
  assign any_evt    = port1_accept | port1_drop | port2_accept | port2_drop;

  // Winner selection for the IDLE->ISSUE decision
  always_comb begin
    win_p1 = port1_req_valid;
    if (contention) begin
      if (PRIO_MODE == 32'd0) begin
        win_p1 = ~last_p1_q;
      end else begin
        win_p1 = starved ? ~hi_is_p1 : hi_is_p1;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    select_d   = select;
    grant1_d   = port1_grant;
    grant2_d   = port2_grant;
    av1_d      = 1'b0;
    av2_d      = 1'b0;
    last_p1_d  = last_p1_q;
    loss_cnt_d = loss_cnt_q;
    err_d      = protocol_err;

    if (state_q == IDLE) begin
      if (any_evt) err_d = 1'b1;
    end else if (nonwin_evt) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (port1_req_valid | port2_req_valid) begin
          state_d   = ISSUE;
          select_d  = win_p1;
          grant1_d  = win_p1;
          grant2_d  = ~win_p1;
          av1_d     = win_p1;
          av2_d     = ~win_p1;
          last_p1_d = win_p1;
          if (PRIO_MODE != 32'd0) begin
            if (win_p1 != hi_is_p1) begin
              loss_cnt_d = '0;
            end else if (contention) begin
              loss_cnt_d = loss_cnt_q + CntW'(1);
            end
          end
        end
      end
      ISSUE: begin
        state_d = RESULT;
      end
      RESULT: begin
        // Simultaneous accept and drop resolves as a drop
        if (w_drop) begin
          state_d  = IDLE;
          grant1_d = 1'b0;
          grant2_d = 1'b0;
          if (w_accept) err_d = 1'b1;
        end else if (w_accept) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (w_sent) begin
          state_d  = IDLE;
          grant1_d = 1'b0;
          grant2_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        grant1_d = 1'b0;
        grant2_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q          <= IDLE;
      select           <= 1'b1;
      port1_grant      <= 1'b0;
      port2_grant      <= 1'b0;
      port1_addr_valid <= 1'b0;
      port2_addr_valid <= 1'b0;
      busy             <= 1'b0;
      protocol_err     <= 1'b0;
      last_p1_q        <= 1'b0;
      loss_cnt_q       <= '0;
    end else begin
      state_q          <= state_d;
      select           <= select_d;
      port1_grant      <= grant1_d;
      port2_grant      <= grant2_d;
      port1_addr_valid <= av1_d;
      port2_addr_valid <= av2_d;
      busy             <= busy_d;
      protocol_err     <= err_d;
      last_p1_q        <= last_p1_d;
      loss_cnt_q       <= loss_cnt_d;
    end
  end

`ifdef RAB_ARB_PERF_CNT_EN
  // Grant counters advance on each IDLE->ISSUE transition, wrapping naturally
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      port1_grant_cnt <= '0;
      port2_grant_cnt <= '0;
    end else if (state_q == IDLE && state_d == ISSUE) begin
      if (select_d) port1_grant_cnt <= port1_grant_cnt + 32'd1;
      else          port2_grant_cnt <= port2_grant_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lookup_arbiter.sv
// Directed bench for lookup_arbiter: per-cycle vector table on a round-robin
// instance plus a starvation sequence on a fixed-priority instance.
module tb_lookup_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Round-robin instance stimulus/response
  logic rst, v1, v2, a1, d1, a2, d2, s1, s2;
  logic av1, av2, sel, g1, g2, bsy, err;
  // Fixed-priority instance stimulus/response
  logic rst_f, v1f, v2f, a1f, d1f, a2f, d2f, s1f, s2f;
  logic av1f, av2f, self_f, g1f, g2f, bsyf, errf;
`ifdef RAB_ARB_PERF_CNT_EN
  logic [31:0] c1, c2, c1f, c2f;
`endif

  lookup_arbiter dut (
    .Clk_CI(clk), .Rst_RI(rst),
    .port1_req_valid(v1), .port2_req_valid(v2),
    .port1_accept(a1), .port1_drop(d1), .port2_accept(a2), .port2_drop(d2),
    .port1_sent(s1), .port2_sent(s2),
    .port1_addr_valid(av1), .port2_addr_valid(av2),
    .select(sel), .port1_grant(g1), .port2_grant(g2), .busy(bsy),
`ifdef RAB_ARB_PERF_CNT_EN
    .port1_grant_cnt(c1), .port2_grant_cnt(c2),
`endif
    .protocol_err(err)
  );

  lookup_arbiter #(.PRIO_MODE(1), .STARVE_LIMIT(3)) dut_fp (
    .Clk_CI(clk), .Rst_RI(rst_f),
    .port1_req_valid(v1f), .port2_req_valid(v2f),
    .port1_accept(a1f), .port1_drop(d1f), .port2_accept(a2f), .port2_drop(d2f),
    .port1_sent(s1f), .port2_sent(s2f),
    .port1_addr_valid(av1f), .port2_addr_valid(av2f),
    .select(self_f), .port1_grant(g1f), .port2_grant(g2f), .busy(bsyf),
`ifdef RAB_ARB_PERF_CNT_EN
    .port1_grant_cnt(c1f), .port2_grant_cnt(c2f),
`endif
    .protocol_err(errf)
  );

  // inputs: {rst, v1 v2, a1 d1, a2 d2, s1 s2}; outputs: {av1 av2, sel, g1 g2, busy, err}
  typedef struct {
    logic [8:0] in;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic add(input logic [8:0] i, input logic [6:0] e);
    vec_t v;
    v.in  = i;
    v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    logic [6:0] got;
    int exp_seq[8];
    int got_id;
    bit found;

    {rst, v1, v2, a1, d1, a2, d2, s1, s2} = 9'b0;
    {v1f, v2f, a1f, d1f, a2f, d2f, s1f, s2f} = 8'b0;
    rst_f = 1'b1;

    add(9'b1_00_00_00_00, 7'b00_1_00_0_0); // reset values
    add(9'b0_00_00_00_00, 7'b00_1_00_0_0);
    add(9'b0_11_00_00_00, 7'b10_1_10_1_0); // p1 first after reset
    add(9'b0_11_00_00_00, 7'b00_1_10_1_0);
    add(9'b0_11_10_00_00, 7'b00_1_10_1_0);
    add(9'b0_11_00_00_10, 7'b00_1_00_0_0);
    add(9'b0_11_00_00_00, 7'b01_0_01_1_0); // p2 next
    add(9'b0_11_00_00_00, 7'b00_0_01_1_0);
    add(9'b0_11_00_10_00, 7'b00_0_01_1_0);
    add(9'b0_11_00_00_01, 7'b00_0_00_0_0);
    add(9'b0_11_00_00_00, 7'b10_1_10_1_0); // p1 again
    add(9'b0_11_00_00_00, 7'b00_1_10_1_0);
    add(9'b0_11_10_00_00, 7'b00_1_10_1_0);
    add(9'b0_11_00_00_01, 7'b00_1_10_1_0); // non-winner sent ignored
    add(9'b0_11_00_00_10, 7'b00_1_00_0_0);
    add(9'b0_11_00_00_00, 7'b01_0_01_1_0); // p2
    add(9'b0_00_00_00_00, 7'b00_0_01_1_0); // valid drop does not abort
    add(9'b0_00_00_00_00, 7'b00_0_01_1_0); // RESULT holds
    add(9'b0_00_00_01_00, 7'b00_0_00_0_0); // drop -> IDLE
    add(9'b0_01_00_00_00, 7'b01_0_01_1_0); // sole p2 beats pointer
    add(9'b0_00_00_00_00, 7'b00_0_01_1_0);
    add(9'b0_00_00_01_00, 7'b00_0_00_0_0);
    add(9'b0_10_00_00_00, 7'b10_1_10_1_0); // sole p1
    add(9'b0_00_00_00_00, 7'b00_1_10_1_0);
    add(9'b0_00_10_00_00, 7'b00_1_10_1_0);
    add(9'b0_00_00_00_10, 7'b00_1_00_0_0);
    add(9'b0_11_00_00_00, 7'b01_0_01_1_0); // contention after p1 -> p2
    add(9'b0_00_00_00_00, 7'b00_0_01_1_0);
    add(9'b0_00_00_10_00, 7'b00_0_01_1_0); // in SEND
    add(9'b1_00_00_00_00, 7'b00_1_00_0_0); // reset mid-sequence
    add(9'b0_00_00_00_01, 7'b00_1_00_0_0); // late sent ignored
    add(9'b0_11_00_00_00, 7'b10_1_10_1_0); // pointer reset -> p1
    add(9'b0_00_00_00_00, 7'b00_1_10_1_0);
    add(9'b0_00_11_00_00, 7'b00_1_00_0_1); // accept+drop -> drop, err
    add(9'b0_00_00_00_00, 7'b00_1_00_0_1); // err sticky
    add(9'b1_00_00_00_00, 7'b00_1_00_0_0);
    add(9'b0_00_00_10_00, 7'b00_1_00_0_1); // accept in IDLE
    add(9'b1_00_00_00_00, 7'b00_1_00_0_0);
    add(9'b0_10_00_00_00, 7'b10_1_10_1_0);
    add(9'b0_00_00_01_00, 7'b00_1_10_1_1); // non-winner drop, state unaffected
    add(9'b0_00_01_00_00, 7'b00_1_00_0_1);
    add(9'b1_00_00_00_00, 7'b00_1_00_0_0);

    foreach (vecs[k]) begin
      @(negedge clk);
      {rst, v1, v2, a1, d1, a2, d2, s1, s2} = vecs[k].in;
      @(posedge clk);
      #1;
      got = {av1, av2, sel, g1, g2, bsy, err};
      n_vec++;
      if (got !== vecs[k].exp) begin
        n_miss++;
        $display("FAIL vec%0d outputs got=%b exp=%b", k, got, vecs[k].exp);
      end
    end

`ifdef RAB_ARB_PERF_CNT_EN
    n_vec++;
    if (c1 !== 32'd0) begin
      n_miss++;
      $display("FAIL cnt_reset got=%0d exp=0", c1);
    end
    @(negedge clk);
    {rst, v1, v2, a1, d1, a2, d2, s1, s2} = 9'b0_10_00_00_00;
    @(posedge clk);
    #1;
    n_vec++;
    if (c1 !== 32'd1 || c2 !== 32'd0) begin
      n_miss++;
      $display("FAIL cnt_incr got=%0d/%0d exp=1/0", c1, c2);
    end
`endif
    @(negedge clk);
    {rst, v1, v2, a1, d1, a2, d2, s1, s2} = 9'b1_00_00_00_00;

    // Starvation sequence on the fixed-priority instance
    exp_seq = '{1, 1, 1, 2, 1, 1, 1, 2};
    @(negedge clk);
    rst_f = 1'b0;
    v1f   = 1'b1;
    v2f   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      found = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk);
        #1;
        if (g1f | g2f) begin
          found = 1'b1;
          break;
        end
      end
      n_vec++;
      if (!found) begin
        n_miss++;
        $display("FAIL starve_grant%0d timeout got=none exp=p%0d", k, exp_seq[k]);
        break;
      end
      got_id = g1f ? 1 : 2;
      if (got_id != exp_seq[k]) begin
        n_miss++;
        $display("FAIL starve_grant%0d got=p%0d exp=p%0d", k, got_id, exp_seq[k]);
      end
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      a1f = g1f;
      a2f = g2f;
      @(posedge clk);
      @(negedge clk);
      s1f = a1f;
      s2f = a2f;
      a1f = 1'b0;
      a2f = 1'b0;
      @(posedge clk);
      @(negedge clk);
      s1f = 1'b0;
      s2f = 1'b0;
    end
    n_vec++;
    if (errf !== 1'b0) begin
      n_miss++;
      $display("FAIL starve_err got=%b exp=0", errf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/lookup_arbiter.md
LOOKUP_ARBITER -- requirements
Module: lookup_arbiter

Interface
REQ-001 SHALL have parameter PRIO_MODE, default 0, meaning 0 = round-robin, 1 = port1 fixed priority, 2 = port2 fixed priority.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning the consecutive losses (1..15) before the low-priority port is forced a grant in fixed-priority mode.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports: Clk_CI  in  1  clock, rising edge.
REQ-005 Ports: Rst_RI  in  1  synchronous active-high reset.
REQ-006 Ports: port1_req_valid, port2_req_valid  in  1 each  the port has a translation request pending.
REQ-007 Ports: port1_accept, port1_drop, port2_accept, port2_drop  in  1 each  lookup result pulses from the lookup FSM.
REQ-008 Ports: port1_sent, port2_sent  in  1 each  the translated transaction has left the port.
REQ-009 Ports: port1_addr_valid, port2_addr_valid  out  1 each  valid forwarded to the lookup FSM for the winning port only.
REQ-010 Ports: select  out  1  1 = port1 owns the lookup, 0 = port2.
REQ-011 Ports: port1_grant, port2_grant  out  1 each  level signal, high while that port owns the lookup.
REQ-012 Ports: busy  out  1  high whenever the state is not IDLE.
REQ-013 Ports: protocol_err  out  1  sticky error flag.

Function
REQ-014 SHALL implement states IDLE, ISSUE, RESULT and SEND, each with registered outputs.
REQ-015 IDLE: if any req_valid, pick the winner, register select and grant, and go to ISSUE next cycle; otherwise stay.
REQ-016 ISSUE: assert the winner's addr_valid for exactly one cycle, then go to RESULT.
REQ-017 RESULT: on the winner's accept, go to SEND; on the winner's drop, go to IDLE; otherwise hold with no timeout.
REQ-018 RESULT: if accept and drop are high together, treat the result as drop and set protocol_err.
REQ-019 SEND: on the winner's sent, go to IDLE; the non-winner's sent is ignored.
REQ-020 Any accept or drop for the non-winning port, or any accept or drop in IDLE, SHALL set protocol_err; the state is unaffected.
REQ-021 Round-robin: on contention, grant the port not granted last; the last-granted pointer updates only on the IDLE->ISSUE transition.
REQ-022 Fixed priority: on contention, grant the priority port.
REQ-023 Fixed priority: a 4-bit loss counter counts contention losses of the low-priority port.
REQ-024 Fixed priority: when the loss counter equals STARVE_LIMIT, grant the low-priority port and clear the counter; the counter also clears on any grant to the low-priority port.
REQ-025 A sole requester SHALL be granted regardless of mode or pointer.
REQ-026 Grant and select SHALL stay stable from ISSUE through the return to IDLE.
REQ-027 A req_valid that drops while its port is granted SHALL NOT abort the sequence.
REQ-028 Minimum request-to-request spacing SHALL be 4 cycles (IDLE, ISSUE, RESULT, SEND with same-cycle sent).

Reset
REQ-029 Rst_RI high at a clock edge SHALL force IDLE; this applies mid-sequence as well.
REQ-030 Reset values: all addr_valid, grant and busy outputs 0; select 1; protocol_err 0; round-robin pointer set so port1 wins next; loss counter 0.
REQ-031 Outputs SHALL reach reset values on the first edge with Rst_RI high.

Configuration
REQ-032 With macro RAB_ARB_PERF_CNT_EN defined, SHALL add outputs port1_grant_cnt and port2_grant_cnt, 32 bits each.
REQ-033 Each grant counter SHALL increment on the IDLE->ISSUE transition for its port, wrap from 0xFFFFFFFF to 0, and clear on reset.
REQ-034 Without RAB_ARB_PERF_CNT_EN, these ports and their counters SHALL be absent; all other behaviour is identical.

Verification
REQ-035 Round-robin test: PRIO_MODE=0, both valids held high, accept and sent returned one cycle after each step -> grants alternate p1, p2, p1, p2; port1 is first after reset.
REQ-036 Drop path: port2 only, drop in RESULT -> port2_addr_valid high exactly one cycle; IDLE two cycles after ISSUE; select = 0 throughout.
REQ-037 Starvation test: PRIO_MODE=1, STARVE_LIMIT=3, both valids held -> grant sequence p1, p1, p1, p2, p1, p1, p1, p2.
REQ-038 Protocol error: in RESULT, port1 accept and drop high together -> return to IDLE and protocol_err = 1, held until reset.
REQ-039 Reset mid-sequence: Rst_RI for one cycle while in SEND -> next cycle busy = 0, grants = 0, select = 1; a later sent pulse is ignored.
REQ-040 Counter wrap: with RAB_ARB_PERF_CNT_EN and port1_grant_cnt forced to 0xFFFFFFFF, one port1 grant -> port1_grant_cnt reads 0.
